// File: rtl/bitwise_unit_seq_pkg.sv
// Shared encodings for the sequential bitwise unit: op select, FSM states,
// and a helper for sizing the slice counter.
package bitwise_unit_seq_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter width for n slices; never below one bit so N=1 still has a register.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitwise_unit_seq_if.sv
// Request/response bundle for the sequential bitwise unit.
interface bitwise_unit_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;

    // Producer/consumer side (drives requests, accepts results).
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, zero
    );

    // Unit side.
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, zero
    );
endinterface

// File: rtl/bitwise_slice.sv
// Combinational CHUNK-bit bitwise op: per-bit gate primitives feeding an 8:1 op mux.
module bitwise_slice
    import bitwise_unit_seq_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [2:0]       op,
    input  logic [CHUNK-1:0] a_slice,
    input  logic [CHUNK-1:0] b_slice,
    output logic [CHUNK-1:0] res
);

    logic [CHUNK-1:0] and_w;
    logic [CHUNK-1:0] or_w;
    logic [CHUNK-1:0] xor_w;
    logic [CHUNK-1:0] nota_w;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        and u_and (and_w[i],  a_slice[i], b_slice[i]);
        or  u_or  (or_w[i],   a_slice[i], b_slice[i]);
        xor u_xor (xor_w[i],  a_slice[i], b_slice[i]);
        not u_not (nota_w[i], a_slice[i]);
    end

    // Op select; inverted forms reuse the base gate outputs.
    always_comb begin
        res = '0;
        case (op)
            OP_AND:  res = and_w;
            OP_OR:   res = or_w;
            OP_XOR:  res = xor_w;
            OP_NOT:  res = nota_w;
            OP_NAND: res = ~and_w;
            OP_NOR:  res = ~or_w;
            OP_XNOR: res = ~xor_w;
            OP_PASS: res = a_slice;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_unit_seq.sv
// Sequential bitwise unit: one CHUNK-bit slice per cycle, LSB slice first,
// valid/ready on both sides, zero flag accumulated across slices.
module bitwise_unit_seq
    import bitwise_unit_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                reset,
    bitwise_unit_seq_if.slave   bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]                  state;
    logic [CW-1:0]               cnt;
    logic [2:0]                  op_q;
    logic [N-1:0][CHUNK-1:0]     a_q;
    logic [N-1:0][CHUNK-1:0]     b_q;
    logic [N-1:0][CHUNK-1:0]     out_q;
    logic                        zacc;
    logic                        zero_q;
    logic [CHUNK-1:0]            sl_res;
    logic                        sl_zero;

    // Handshake flags come straight from registered state.
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;

    bitwise_slice #(.CHUNK(CHUNK)) u_slice (
        .op      (op_q),
        .a_slice (a_q[cnt]),
        .b_slice (b_q[cnt]),
        .res     (sl_res)
    );

    assign sl_zero = (sl_res == '0);

    // FSM plus datapath: capture on accept, write one slice per BUSY edge,
    // hold results in DONE until the consumer takes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            out_q  <= '0;
            zacc   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.op;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        out_q <= '0;
                        zacc  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    out_q[cnt] <= sl_res;
                    zacc       <= zacc & sl_zero;
                    if (cnt == LAST) begin
                        // Final slice folds into the flag on the same edge.
                        zero_q <= zacc & sl_zero;
                        cnt    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_unit_seq.sv
// Directed bench for bitwise_unit_seq: table of vectors on a 16/4 instance,
// plus backpressure, mid-op reset, and the 16/16 and 32/8 configurations.
module tb_bitwise_unit_seq;
    import bitwise_unit_seq_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bitwise_unit_seq_if #(.WIDTH(16)) if0 ();
    bitwise_unit_seq_if #(.WIDTH(16)) if1 ();
    bitwise_unit_seq_if #(.WIDTH(32)) if2 ();

    bitwise_unit_seq #(.WIDTH(16), .CHUNK(4))  d0 (.clk(clk), .reset(reset), .bus(if0));
    bitwise_unit_seq #(.WIDTH(16), .CHUNK(16)) d1 (.clk(clk), .reset(reset), .bus(if1));
    bitwise_unit_seq #(.WIDTH(32), .CHUNK(8))  d2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic        expz;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0: begin if0.in_valid = v; if0.op = op; if0.a = a[15:0]; if0.b = b[15:0]; end
            1: begin if1.in_valid = v; if1.op = op; if1.a = a[15:0]; if1.b = b[15:0]; end
            default: begin if2.in_valid = v; if2.op = op; if2.a = a; if2.b = b; end
        endcase
    endtask

    function automatic logic ov(input int sel);
        case (sel)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic [31:0] outv(input int sel);
        case (sel)
            0:       return {16'h0, if0.out};
            1:       return {16'h0, if1.out};
            default: return if2.out;
        endcase
    endfunction

    function automatic logic zv(input int sel);
        case (sel)
            0:       return if0.zero;
            1:       return if1.zero;
            default: return if2.zero;
        endcase
    endfunction

    // Issue one op and count edges after the accept edge until out_valid.
    task automatic run(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output logic z, output int lat);
        @(negedge clk);
        set_in(sel, 1'b1, op, a, b);
        @(posedge clk);
        @(negedge clk);
        set_in(sel, 1'b0, 3'd0, 32'h0, 32'h0);
        lat = 0;
        while (!ov(sel) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = outv(sel);
        z   = zv(sel);
    endtask

    logic [31:0] res;
    logic        z;
    int          lat;

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{"and",  OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
        vecs[1] = '{"xor",  OP_XOR,  16'h1234, 16'h1234, 16'h0000, 1'b1};
        vecs[2] = '{"xnor", OP_XNOR, 16'h1234, 16'h1234, 16'hFFFF, 1'b0};
        vecs[3] = '{"not",  OP_NOT,  16'h00FF, 16'hABCD, 16'hFF00, 1'b0};
        vecs[4] = '{"pass", OP_PASS, 16'h8001, 16'h5555, 16'h8001, 1'b0};
        vecs[5] = '{"nand", OP_NAND, 16'h0F0F, 16'h00FF, 16'hFFF0, 1'b0};
        vecs[6] = '{"or",   OP_OR,   16'h0F00, 16'h00F0, 16'h0FF0, 1'b0};

        reset = 1'b1;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 3'd0, 32'h0, 32'h0);
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'h0, if0.in_ready},  32'h1);
        check("rst_out_valid", {31'h0, if0.out_valid}, 32'h0);
        check("rst_out",       {16'h0, if0.out},       32'h0);
        check("rst_zero",      {31'h0, if0.zero},      32'h0);
        reset = 1'b0;

        // Table-driven ops on the 16/4 instance.
        for (int i = 0; i < 7; i++) begin
            run(0, vecs[i].op, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, res, z, lat);
            check({vecs[i].name, "_lat"},  lat, 4);
            check({vecs[i].name, "_out"},  res, {16'h0, vecs[i].exp});
            check({vecs[i].name, "_zero"}, {31'h0, z}, {31'h0, vecs[i].expz});
            @(negedge clk);
            check({vecs[i].name, "_back_idle"}, {30'h0, if0.in_ready, if0.out_valid}, 32'h2);
        end

        // Backpressure: DONE holds while out_ready=0, in_valid pulses ignored.
        if0.out_ready = 1'b0;
        run(0, OP_NOR, 32'h0000, 32'h0001, res, z, lat);
        check("nor_lat",  lat, 4);
        check("nor_out",  res, 32'hFFFE);
        check("nor_zero", {31'h0, z}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            set_in(0, c[0] ? 1'b0 : 1'b1, OP_AND, 32'h0000, 32'h0000);
            @(negedge clk);
            check("bp_hold_flags", {30'h0, if0.in_ready, if0.out_valid}, 32'h1);
            check("bp_hold_out",   {15'h0, if0.zero, if0.out}, 32'h0000FFFE);
        end
        set_in(0, 1'b0, 3'd0, 32'h0, 32'h0);
        if0.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {30'h0, if0.in_ready, if0.out_valid}, 32'h2);
        check("bp_out_kept", {16'h0, if0.out}, 32'hFFFE);
        @(negedge clk);
        check("bp_stay_idle", {30'h0, if0.in_ready, if0.out_valid}, 32'h2);

        // Reset after two slices have been written.
        set_in(0, 1'b1, OP_AND, 32'hF0F0, 32'hFF00);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("mid_partial_out", {16'h0, if0.out}, 32'h0000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_flags", {30'h0, if0.in_ready, if0.out_valid}, 32'h2);
        check("midrst_out",   {15'h0, if0.zero, if0.out}, 32'h0);
        run(0, OP_OR, 32'h0F00, 32'h00F0, res, z, lat);
        check("midrst_or_lat", lat, 4);
        check("midrst_or_out", res, 32'h0FF0);

        // Single-slice configuration.
        run(1, OP_NAND, 32'hFFFF, 32'hFFFF, res, z, lat);
        check("c16_lat",  lat, 1);
        check("c16_out",  res, 32'h0000);
        check("c16_zero", {31'h0, z}, 32'h1);

        // 32-bit, 8-bit slices.
        run(2, OP_AND, 32'hFFFFFFFF, 32'h80000001, res, z, lat);
        check("w32_lat",  lat, 4);
        check("w32_out",  res, 32'h80000001);
        check("w32_zero", {31'h0, z}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
